// File: rtl/aurora_nfc_tx.sv
// ---------------------------------------------------------------------------
// aurora_nfc_tx
//
// Purpose:
//   Builds Aurora native-flow-control requests toward the link partner from
//   the local RX FIFO fill state. Sends XOFF when the RX FIFO nears full,
//   refreshes XOFF periodically while it stays full, and sends XON once the
//   FIFO has shown free space for a hysteresis period.
//
// Ports:
//   clk_u               in   user clock
//   rst                 in   synchronous, active-high reset
//   channel_up          in   Aurora channel up
//   fifo_rx_almost_full in   RX FIFO almost-full flag (clk_u domain)
//   nfc_tready          in   core accepts the NFC word
//   nfc_tvalid          out  NFC request valid
//   nfc_tdata[15:0]     out  bit 15 = XOFF(1)/XON(0), bits 14:0 zero
//   paused              out  high from XOFF handshake until XON handshake
//
// Optional build macro NFC_STATS_EN adds:
//   xoff_sent_count[31:0] out  XOFF handshakes (refreshes included)
//   xon_sent_count[31:0]  out  XON handshakes
//   paused_cycles[31:0]   out  cycles with paused high
// ---------------------------------------------------------------------------
module aurora_nfc_tx #(
  parameter int RESUME_DELAY     = 16,
  parameter int REFRESH_INTERVAL = 1024,
  parameter int CNT_W            = 16
) (
  input  logic        clk_u,
  input  logic        rst,
  input  logic        channel_up,
  input  logic        fifo_rx_almost_full,
  input  logic        nfc_tready,
  output logic        nfc_tvalid,
  output logic [15:0] nfc_tdata,
  output logic        paused
`ifdef NFC_STATS_EN
  ,
  output logic [31:0] xoff_sent_count,
  output logic [31:0] xon_sent_count,
  output logic [31:0] paused_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_SEND_XOFF   = 3'd1,
    S_PAUSED      = 3'd2,
    S_WAIT_RESUME = 3'd3,
    S_SEND_XON    = 3'd4
  } state_t;

  localparam logic [15:0]      LP_XOFF_WORD   = 16'h8000;
  localparam logic [15:0]      LP_XON_WORD    = 16'h0000;
  localparam logic [CNT_W-1:0] LP_RESUME      = CNT_W'(RESUME_DELAY);
  localparam bit               LP_REFRESH_EN  = (REFRESH_INTERVAL != 0);
  // Last PAUSED count before a refresh; guarded so a disabled refresh does
  // not produce a negative constant.
  localparam logic [CNT_W-1:0] LP_REFRESH_LAST =
    CNT_W'((REFRESH_INTERVAL == 0) ? 0 : (REFRESH_INTERVAL - 1));
  localparam logic [CNT_W-1:0] LP_CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_paused;
  logic             w_paused_nxt;

  // Counter holds at all-ones instead of wrapping, so a very long stay in a
  // state can never alias back onto a small threshold.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + LP_CNT_ONE);
  endfunction

  // State / counter / paused registers
  always_ff @(posedge clk_u) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_paused <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_paused <= w_paused_nxt;
    end
  end

  // Next-state logic. Loss of channel overrides everything, including a
  // handshake in the same cycle: the core discards NFC while down, so that
  // handshake is treated as never having happened.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_paused_nxt = r_paused;
    if (!channel_up) begin
      w_state_nxt  = S_IDLE;
      w_cnt_nxt    = '0;
      w_paused_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (fifo_rx_almost_full) begin
            w_state_nxt = S_SEND_XOFF;
          end
        end
        S_SEND_XOFF: begin
          if (nfc_tready) begin
            w_state_nxt  = S_PAUSED;
            w_cnt_nxt    = '0;
            w_paused_nxt = 1'b1;
          end
        end
        S_PAUSED: begin
          if (!fifo_rx_almost_full) begin
            // This low cycle already counts toward the resume delay.
            w_state_nxt = S_WAIT_RESUME;
            w_cnt_nxt   = LP_CNT_ONE;
          end else begin
            w_cnt_nxt = sat_inc(r_cnt);
            if (LP_REFRESH_EN && (r_cnt == LP_REFRESH_LAST)) begin
              w_state_nxt = S_SEND_XOFF;
            end
          end
        end
        S_WAIT_RESUME: begin
          if (fifo_rx_almost_full) begin
            // Partner is still paused, so no new XOFF is needed here.
            w_state_nxt = S_PAUSED;
            w_cnt_nxt   = '0;
          end else if (r_cnt == LP_RESUME) begin
            w_state_nxt = S_SEND_XON;
          end else begin
            w_cnt_nxt = sat_inc(r_cnt);
          end
        end
        S_SEND_XON: begin
          // XON is never withdrawn once offered; a new almost-full only
          // matters at the handshake.
          if (nfc_tready) begin
            w_paused_nxt = 1'b0;
            w_cnt_nxt    = '0;
            w_state_nxt  = fifo_rx_almost_full ? S_SEND_XOFF : S_IDLE;
          end
        end
        default: begin
          w_state_nxt  = S_IDLE;
          w_cnt_nxt    = '0;
          w_paused_nxt = 1'b0;
        end
      endcase
    end
  end

  // Output decode: tvalid/tdata depend only on the registered state, so
  // they stay stable for the whole time a word waits for tready.
  always_comb begin
    nfc_tvalid = 1'b0;
    nfc_tdata  = LP_XON_WORD;
    case (r_state)
      S_SEND_XOFF: begin
        nfc_tvalid = 1'b1;
        nfc_tdata  = LP_XOFF_WORD;
      end
      S_SEND_XON: begin
        nfc_tvalid = 1'b1;
        nfc_tdata  = LP_XON_WORD;
      end
      default: begin
        nfc_tvalid = 1'b0;
        nfc_tdata  = LP_XON_WORD;
      end
    endcase
  end

  assign paused = r_paused;

`ifdef NFC_STATS_EN
  logic [31:0] r_xoff_cnt;
  logic [31:0] r_xon_cnt;
  logic [31:0] r_paused_cyc;
  logic        w_hs_xoff;
  logic        w_hs_xon;

  // A handshake only counts while the channel is up.
  assign w_hs_xoff = channel_up && nfc_tready && (r_state == S_SEND_XOFF);
  assign w_hs_xon  = channel_up && nfc_tready && (r_state == S_SEND_XON);

  // Statistics counters, free-running modulo 2^32
  always_ff @(posedge clk_u) begin
    if (rst) begin
      r_xoff_cnt   <= '0;
      r_xon_cnt    <= '0;
      r_paused_cyc <= '0;
    end else begin
      if (w_hs_xoff) r_xoff_cnt   <= r_xoff_cnt + 32'd1;
      if (w_hs_xon)  r_xon_cnt    <= r_xon_cnt + 32'd1;
      if (r_paused)  r_paused_cyc <= r_paused_cyc + 32'd1;
    end
  end

  assign xoff_sent_count = r_xoff_cnt;
  assign xon_sent_count  = r_xon_cnt;
  assign paused_cycles   = r_paused_cyc;
`else
  // Statistics not built: no extra ports or registers.
`endif

endmodule

// File: tb/tb_aurora_nfc_tx.sv
// ---------------------------------------------------------------------------
// tb_aurora_nfc_tx
//
// Bench for aurora_nfc_tx. A behavioural model tracks the link in terms of
// "pending word", "partner paused", and streaks of almost-full high/low
// cycles; a compare process checks every cycle after reset. Directed
// scenarios pin the model with literal expectations, then randomized
// traffic runs against the model. Honors NFC_STATS_EN when defined.
// ---------------------------------------------------------------------------
module tb_aurora_nfc_tx;

  localparam int RD = 16;
  localparam int RI = 8;
  localparam int CW = 16;

  logic        clk_u = 1'b0;
  logic        rst;
  logic        channel_up;
  logic        af;
  logic        tready;
  logic        nfc_tvalid;
  logic [15:0] nfc_tdata;
  logic        paused;
`ifdef NFC_STATS_EN
  logic [31:0] xoff_sent_count;
  logic [31:0] xon_sent_count;
  logic [31:0] paused_cycles;
`endif

  always #5 clk_u = ~clk_u;

  aurora_nfc_tx #(
    .RESUME_DELAY    (RD),
    .REFRESH_INTERVAL(RI),
    .CNT_W           (CW)
  ) dut (
    .clk_u              (clk_u),
    .rst                (rst),
    .channel_up         (channel_up),
    .fifo_rx_almost_full(af),
    .nfc_tready         (tready),
    .nfc_tvalid         (nfc_tvalid),
    .nfc_tdata          (nfc_tdata),
    .paused             (paused)
`ifdef NFC_STATS_EN
    ,
    .xoff_sent_count    (xoff_sent_count),
    .xon_sent_count     (xon_sent_count),
    .paused_cycles      (paused_cycles)
`endif
  );

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_pending;   // a word is being offered
  bit          m_is_xoff;   // offered word is XOFF
  bit          m_paused;    // partner believed paused
  int          m_hi;        // almost-full-high cycles since last reference point
  int          m_low;       // consecutive almost-full-low cycles while paused
  int unsigned m_xoffs, m_xons, m_pcyc;

  task automatic m_clear_link();
    m_pending = 0; m_is_xoff = 0; m_paused = 0; m_hi = 0; m_low = 0;
  endtask

  always @(posedge clk_u) begin
    if (rst) begin
      m_clear_link();
      m_xoffs = 0; m_xons = 0; m_pcyc = 0;
    end else begin
      if (m_paused) m_pcyc++;
      if (!channel_up) begin
        m_clear_link();
      end else if (m_pending) begin
        if (tready) begin
          m_hi = 0; m_low = 0;
          if (m_is_xoff) begin
            m_xoffs++; m_pending = 0; m_paused = 1;
          end else begin
            m_xons++; m_paused = 0;
            m_pending = af; m_is_xoff = af;
          end
        end
      end else if (!m_paused) begin
        if (af) begin m_pending = 1; m_is_xoff = 1; end
      end else if (m_low > 0) begin
        // resume hysteresis: needs RD+1 consecutive low cycles in total
        if (af) begin
          m_low = 0; m_hi = 0;
        end else begin
          m_low++;
          if (m_low == RD + 1) begin m_pending = 1; m_is_xoff = 0; end
        end
      end else begin
        if (!af) begin
          m_low = 1;
        end else begin
          if (m_hi < 65535) m_hi++;
          if (RI != 0 && m_hi == RI) begin m_pending = 1; m_is_xoff = 1; end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_u) begin
    if (chk_en) begin
      check("tvalid", {31'd0, nfc_tvalid}, {31'd0, m_pending});
      check("tdata", {16'd0, nfc_tdata}, (m_pending && m_is_xoff) ? 32'h8000 : 32'h0);
      check("paused", {31'd0, paused}, {31'd0, m_paused});
`ifdef NFC_STATS_EN
      check("xoff_cnt", xoff_sent_count, m_xoffs);
      check("xon_cnt", xon_sent_count, m_xons);
      check("paused_cyc", paused_cycles, m_pcyc);
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_u);
  endtask

  task automatic lit(input string name, input bit v, input logic [15:0] d, input bit p);
    check({name, "_tvalid"}, {31'd0, nfc_tvalid}, {31'd0, v});
    check({name, "_tdata"}, {16'd0, nfc_tdata}, {16'd0, d});
    check({name, "_paused"}, {31'd0, paused}, {31'd0, p});
  endtask

  initial begin
    int n;
    rst = 1; channel_up = 0; af = 0; tready = 0;
    cyc(1);
    chk_en = 1;
    cyc(2);
    lit("reset", 0, 16'h0000, 0);
`ifdef NFC_STATS_EN
    check("reset_xoff_cnt", xoff_sent_count, 0);
`endif
    rst = 0; channel_up = 1; tready = 1;
    cyc(9);

    // XOFF one cycle after the flag, single-cycle handshake
    af = 1;
    cyc(1); lit("xoff_first", 1, 16'h8000, 0);
    cyc(1); lit("xoff_hs", 0, 16'h0000, 1);
    // refresh after 8 PAUSED cycles
    cyc(7); lit("refresh_pre", 0, 16'h0000, 1);
    cyc(1); lit("refresh", 1, 16'h8000, 1);
    cyc(1); lit("refresh_hs", 0, 16'h0000, 1);
`ifdef NFC_STATS_EN
    check("xoff_cnt_two", xoff_sent_count, 2);
`endif

    // resume after hysteresis
    af = 0;
    cyc(16); lit("resume_pre", 0, 16'h0000, 1);
    cyc(1);  lit("xon", 1, 16'h0000, 1);
    cyc(1);  lit("xon_hs", 0, 16'h0000, 0);
    cyc(3);

    // back-pressure on XOFF with almost-full toggling
    tready = 0; af = 1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      lit("stall", 1, 16'h8000, 0);
      af = i[0];
    end
    af = 1; tready = 1;
    cyc(1); lit("stall_hs", 0, 16'h0000, 1);

    // short low burst does not release the partner
    af = 0;
    cyc(10); lit("short_low", 0, 16'h0000, 1);
    af = 1;
    cyc(2);  lit("short_low_back", 0, 16'h0000, 1);

    // channel drop while a word is offered
    tready = 0;
    n = 0;
    while (!nfc_tvalid && n < 40) begin cyc(1); n++; end
    check("wait_tvalid", {31'd0, nfc_tvalid}, 32'd1);
    channel_up = 0;
    cyc(1); lit("chan_down", 0, 16'h0000, 0);
    channel_up = 1; tready = 1;
    cyc(3); lit("rearm", 0, 16'h0000, 1);

    // reset mid-PAUSED
    rst = 1;
    cyc(1); lit("rst_mid", 0, 16'h0000, 0);
`ifdef NFC_STATS_EN
    check("rst_xoff_cnt", xoff_sent_count, 0);
    check("rst_pcyc", paused_cycles, 0);
`endif
    rst = 0; af = 0;

    // randomized traffic
    for (int i = 0; i < 6000; i++) begin
      cyc(1);
      if ($urandom_range(0, 24) == 0) af = ~af;
      tready = ($urandom_range(0, 3) != 0);
      if (channel_up) begin
        if ($urandom_range(0, 299) == 0) channel_up = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        channel_up = 1;
      end
      rst = ($urandom_range(0, 1499) == 0);
    end
    rst = 0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
